// File: rtl/fetch_issue_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_issue_ctrl
//
// Fetch/issue front end. Owns the program counter, reads the combinational
// instruction memory and each cycle hands either the fetched instruction or a
// NOP bubble to decode. Read-after-write hazards against recently issued
// destination registers produce bubbles automatically. A brn holds fetch until
// EX resolves it.
//
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset
//   start        pulse, IDLE -> RUN
//   stop         pulse, any state -> IDLE (highest priority)
//   imem_addr    instruction memory address (= pc)
//   imem_data    instruction at imem_addr, same cycle
//   br_resolve   EX resolved the outstanding brn (only seen in BR_WAIT)
//   br_taken     qualifies br_resolve
//   br_target    redirect pc when taken
//   instr_out    registered instruction to ID, 0 = bubble
//   instr_valid  registered, 1 when instr_out is a real issue
//   pc_out       registered pc of the issued instruction
//   stall_cnt    saturating count of bubbles issued in RUN/BR_WAIT
//   state        00 IDLE, 01 RUN, 10 BR_WAIT
// -----------------------------------------------------------------------------
module fetch_issue_ctrl #(
   parameter int SB_DEPTH = 4,
   parameter int CNT_W    = 16
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             start,
   input  logic             stop,
   output logic [7:0]       imem_addr,
   input  logic [31:0]      imem_data,
   input  logic             br_resolve,
   input  logic             br_taken,
   input  logic [7:0]       br_target,
   output logic [31:0]      instr_out,
   output logic             instr_valid,
   output logic [7:0]       pc_out,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'b00,
      ST_RUN     = 2'b01,
      ST_BR_WAIT = 2'b10
   } state_e;

   localparam logic [3:0] OP_ADD  = 4'b0100;
   localparam logic [3:0] OP_INC  = 4'b0101;
   localparam logic [3:0] OP_SUB  = 4'b0111;
   localparam logic [3:0] OP_BRN  = 4'b1011;
   localparam logic [3:0] OP_LD   = 4'b1110;
   localparam logic [3:0] OP_SVPC = 4'b1111;

   // The write-back distance counts the issue cycle itself: an instruction
   // issued on edge t may have a dependent issued on edge t+SB_DEPTH. Between
   // those edges the producer must block for SB_DEPTH-1 fetch cycles, which is
   // exactly the number of registered slots needed (SB_DEPTH >= 2 assumed).
   localparam int SB_REGS = SB_DEPTH - 1;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   state_e                    state_q, state_d;
   logic [7:0]                pc_q, pc_d;
   logic [SB_REGS-1:0]        sb_v_q, sb_v_d;
   logic [SB_REGS-1:0][5:0]   sb_rd_q, sb_rd_d;
   logic [31:0]               instr_out_q, instr_out_d;
   logic                      instr_valid_q, instr_valid_d;
   logic [7:0]                pc_out_q, pc_out_d;
   logic [CNT_W-1:0]          stall_cnt_q, stall_cnt_d;

   // ---------------------------------------------------------------------------
   // Decode of the instruction currently presented by memory
   // ---------------------------------------------------------------------------
   logic [3:0] op;
   logic [5:0] rd, rs, rt;
   logic       reads_rs, reads_rt, writes_rd;
   logic       hazard;

   assign op = imem_data[31:28];
   assign rd = imem_data[27:22];
   assign rs = imem_data[21:16];
   assign rt = imem_data[15:10];

   always_comb begin
      reads_rs  = (op == OP_ADD) || (op == OP_INC) || (op == OP_SUB) ||
                  (op == OP_LD)  || (op == OP_BRN);
      reads_rt  = (op == OP_ADD) || (op == OP_SUB);
      writes_rd = (op == OP_ADD) || (op == OP_INC) || (op == OP_SUB) ||
                  (op == OP_LD)  || (op == OP_SVPC);
   end

   always_comb begin
      hazard = 1'b0;
      for (int i = 0; i < SB_REGS; i++) begin
         if (sb_v_q[i] && ((reads_rs && sb_rd_q[i] == rs) ||
                           (reads_rt && sb_rd_q[i] == rt)))
            hazard = 1'b1;
      end
   end

   // ---------------------------------------------------------------------------
   // Next state / issue
   // ---------------------------------------------------------------------------
   logic stall_inc;

   always_comb begin
      state_d       = state_q;
      pc_d          = pc_q;
      instr_out_d   = '0;
      instr_valid_d = 1'b0;
      pc_out_d      = pc_out_q;
      stall_inc     = 1'b0;

      // Scoreboard ages every cycle regardless of state.
      for (int i = SB_REGS - 1; i > 0; i--) begin
         sb_v_d[i]  = sb_v_q[i-1];
         sb_rd_d[i] = sb_rd_q[i-1];
      end
      sb_v_d[0]  = 1'b0;
      sb_rd_d[0] = rd;

      unique case (state_q)
         ST_IDLE: begin
            if (start)
               state_d = ST_RUN;
         end
         ST_RUN: begin
            if (hazard) begin
               stall_inc = 1'b1;
            end else begin
               instr_out_d   = imem_data;
               instr_valid_d = 1'b1;
               pc_out_d      = pc_q;
               pc_d          = pc_q + 8'd1;
               sb_v_d[0]     = writes_rd;
               if (op == OP_BRN)
                  state_d = ST_BR_WAIT;
            end
         end
         ST_BR_WAIT: begin
            stall_inc = 1'b1;
            if (br_resolve) begin
               if (br_taken)
                  pc_d = br_target;
               state_d = ST_RUN;
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // stop overrides everything decided above; a pending branch is dropped.
      if (stop) begin
         state_d       = ST_IDLE;
         pc_d          = pc_q;
         sb_v_d        = '0;
         instr_out_d   = '0;
         instr_valid_d = 1'b0;
         pc_out_d      = pc_out_q;
         stall_inc     = 1'b0;
      end

      stall_cnt_d = stall_cnt_q;
      if (stall_inc && !(&stall_cnt_q))
         stall_cnt_d = stall_cnt_q + 1'b1;
   end

   // ---------------------------------------------------------------------------
   // Registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= ST_IDLE;
         pc_q          <= '0;
         sb_v_q        <= '0;
         sb_rd_q       <= '0;
         instr_out_q   <= '0;
         instr_valid_q <= 1'b0;
         pc_out_q      <= '0;
         stall_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         pc_q          <= pc_d;
         sb_v_q        <= sb_v_d;
         sb_rd_q       <= sb_rd_d;
         instr_out_q   <= instr_out_d;
         instr_valid_q <= instr_valid_d;
         pc_out_q      <= pc_out_d;
         stall_cnt_q   <= stall_cnt_d;
      end
   end

   assign imem_addr   = pc_q;
   assign instr_out   = instr_out_q;
   assign instr_valid = instr_valid_q;
   assign pc_out      = pc_out_q;
   assign stall_cnt   = stall_cnt_q;
   assign state       = state_q;

endmodule

// File: tb/tb_fetch_issue_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fetch_issue_ctrl
//
// Directed bench for fetch_issue_ctrl. A small bench-owned memory array feeds
// imem_data; expected values are hand-derived per scenario. The stall counter
// is narrowed so saturation is reachable in a short run.
// -----------------------------------------------------------------------------
module tb_fetch_issue_ctrl;

   localparam int CW = 4;

   logic          clock = 1'b0;
   logic          reset_n = 1'b1;
   logic          start = 1'b0;
   logic          stop = 1'b0;
   logic          br_resolve = 1'b0;
   logic          br_taken = 1'b0;
   logic [7:0]    br_target = 8'h00;
   logic [7:0]    imem_addr;
   logic [31:0]   imem_data;
   logic [31:0]   instr_out;
   logic          instr_valid;
   logic [7:0]    pc_out;
   logic [CW-1:0] stall_cnt;
   logic [1:0]    state;

   logic [31:0]   mem [256];
   int            n_cmp = 0;
   int            n_bad = 0;

   always #5 clock = ~clock;

   assign imem_data = mem[imem_addr];

   fetch_issue_ctrl #(.SB_DEPTH(4), .CNT_W(CW)) dut (
      .clock       (clock),
      .reset_n     (reset_n),
      .start       (start),
      .stop        (stop),
      .imem_addr   (imem_addr),
      .imem_data   (imem_data),
      .br_resolve  (br_resolve),
      .br_taken    (br_taken),
      .br_target   (br_target),
      .instr_out   (instr_out),
      .instr_valid (instr_valid),
      .pc_out      (pc_out),
      .stall_cnt   (stall_cnt),
      .state       (state)
   );

   function automatic logic [31:0] enc(input logic [3:0] op, input logic [5:0] rd,
                                       input logic [5:0] rs, input logic [5:0] rt,
                                       input logic [9:0] imm);
      return {op, rd, rs, rt, imm};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic clr_mem;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
   endtask

   // Reset, then start; returns one step after entering RUN with pc = 0.
   task automatic boot;
      start = 0; stop = 0; br_resolve = 0; br_taken = 0;
      reset_n = 0;
      tick;
      reset_n = 1;
      start = 1;
      tick;
      start = 0;
   endtask

   logic [31:0] w_add, w_inc, w_sub, w_incm, w_brn, w_mark, w_tgt, w_inc1, w_dep;

   initial begin
      w_add  = enc(4'b0100, 6'd5, 6'd2, 6'd3, 10'd0);    // add x5,x2,x3
      w_inc  = enc(4'b0101, 6'd4, 6'd4, 6'd0, 10'd1);    // inc x4,x4,1
      w_sub  = enc(4'b0111, 6'd4, 6'd4, 6'd4, 10'd0);    // sub x4,x4,x4
      w_incm = enc(4'b0101, 6'd4, 6'd4, 6'd0, 10'h3FF);  // inc x4,x4,-1
      w_brn  = enc(4'b1011, 6'd0, 6'd10, 6'd0, 10'd0);   // brn x10
      w_mark = enc(4'b0100, 6'd1, 6'd2, 6'd3, 10'd0);    // add x1,x2,x3
      w_tgt  = enc(4'b0101, 6'd9, 6'd9, 6'd0, 10'd1);    // inc x9,x9,1
      w_inc1 = enc(4'b0101, 6'd1, 6'd1, 6'd0, 10'd1);    // inc x1,x1,1
      w_dep  = enc(4'b0100, 6'd2, 6'd1, 6'd1, 10'd0);    // add x2,x1,x1

      // ---- reset values ----
      clr_mem;
      #1 reset_n = 0;
      #1;
      chk("rst_instr", instr_out, 32'h0);
      chk("rst_valid", 32'(instr_valid), 0);
      chk("rst_pcout", 32'(pc_out), 0);
      chk("rst_stall", 32'(stall_cnt), 0);
      chk("rst_state", 32'(state), 0);
      chk("rst_addr",  32'(imem_addr), 0);

      // ---- independent back-to-back issue ----
      clr_mem;
      mem[0] = w_add; mem[1] = w_inc;
      boot;
      chk("t1_state_run", 32'(state), 1);
      chk("t1_no_issue_yet", 32'(instr_valid), 0);
      tick;
      chk("t1_add_v",  32'(instr_valid), 1);
      chk("t1_add_i",  instr_out, w_add);
      chk("t1_add_pc", 32'(pc_out), 0);
      tick;
      chk("t1_inc_v",  32'(instr_valid), 1);
      chk("t1_inc_i",  instr_out, w_inc);
      chk("t1_inc_pc", 32'(pc_out), 1);
      chk("t1_stall",  32'(stall_cnt), 0);

      // ---- RAW hazard: dependent issues SB_DEPTH cycles later ----
      clr_mem;
      mem[0] = w_sub; mem[1] = w_incm;
      boot;
      tick;
      chk("t2_sub_i", instr_out, w_sub);
      for (int k = 1; k <= 3; k++) begin
         tick;
         chk($sformatf("t2_bubble%0d", k), 32'(instr_valid), 0);
         chk($sformatf("t2_hold_pc%0d", k), 32'(imem_addr), 1);
      end
      tick;
      chk("t2_inc_v",  32'(instr_valid), 1);
      chk("t2_inc_i",  instr_out, w_incm);
      chk("t2_inc_pc", 32'(pc_out), 1);
      chk("t2_stall",  32'(stall_cnt), 3);

      // ---- branch taken ----
      clr_mem;
      mem[5] = w_brn; mem[6] = w_mark; mem[32] = w_tgt;
      boot;
      for (int i = 0; i < 6; i++) begin
         tick;
         chk($sformatf("t3_seq_pc%0d", i), 32'(pc_out), i);
         chk($sformatf("t3_seq_v%0d", i), 32'(instr_valid), 1);
      end
      chk("t3_brwait", 32'(state), 2);
      chk("t3_hold_addr", 32'(imem_addr), 6);
      tick; chk("t3_bw1", 32'(instr_valid), 0);
      tick; chk("t3_bw2", 32'(instr_valid), 0);
      br_resolve = 1; br_taken = 1; br_target = 8'h20;
      tick;
      br_resolve = 0; br_taken = 0;
      chk("t3_bw3", 32'(instr_valid), 0);
      chk("t3_run", 32'(state), 1);
      chk("t3_redirect", 32'(imem_addr), 'h20);
      tick;
      chk("t3_tgt_v",  32'(instr_valid), 1);
      chk("t3_tgt_pc", 32'(pc_out), 'h20);
      chk("t3_tgt_i",  instr_out, w_tgt);
      chk("t3_stall",  32'(stall_cnt), 3);

      // ---- branch not taken; stray resolve in RUN ignored ----
      boot;
      tick; tick;
      br_resolve = 1; br_taken = 1; br_target = 8'h40;
      tick;
      br_resolve = 0; br_taken = 0;
      chk("t4_stray_pc", 32'(pc_out), 2);
      chk("t4_stray_st", 32'(state), 1);
      tick;
      chk("t4_stray_next", 32'(pc_out), 3);
      tick; tick;
      chk("t4_brn_pc", 32'(pc_out), 5);
      chk("t4_brwait", 32'(state), 2);
      tick; tick;
      br_resolve = 1; br_taken = 0; br_target = 8'h20;
      tick;
      br_resolve = 0;
      chk("t4_run", 32'(state), 1);
      chk("t4_addr", 32'(imem_addr), 6);
      tick;
      chk("t4_fall_v",  32'(instr_valid), 1);
      chk("t4_fall_pc", 32'(pc_out), 6);
      chk("t4_fall_i",  instr_out, w_mark);
      chk("t4_stall",   32'(stall_cnt), 3);

      // ---- pc wrap 255 -> 0, counter saturation, stop in BR_WAIT ----
      clr_mem;
      mem[0] = w_brn; mem[255] = w_inc1; mem[1] = w_dep;
      boot;
      tick;
      chk("t5_brn_pc", 32'(pc_out), 0);
      br_resolve = 1; br_taken = 1; br_target = 8'hFF;
      tick;
      br_resolve = 0; br_taken = 0;
      chk("t5_addr_ff", 32'(imem_addr), 'hFF);
      tick;
      chk("t5_ff_v",  32'(instr_valid), 1);
      chk("t5_ff_pc", 32'(pc_out), 'hFF);
      chk("t5_wrap_addr", 32'(imem_addr), 0);
      tick;
      chk("t5_wrap_pc", 32'(pc_out), 0);
      chk("t5_wrap_v",  32'(instr_valid), 1);
      chk("t5_brwait",  32'(state), 2);
      for (int k = 0; k < 20; k++) tick;
      chk("t5_sat", 32'(stall_cnt), 15);
      stop = 1;
      tick;
      stop = 0;
      chk("t6_idle", 32'(state), 0);
      chk("t6_bubble", 32'(instr_valid), 0);
      chk("t6_pc_keep", 32'(imem_addr), 1);
      tick;
      chk("t6_idle_hold", 32'(state), 0);
      chk("t6_idle_nocnt", 32'(stall_cnt), 15);
      chk("t6_idle_pc", 32'(imem_addr), 1);

      // ---- stop clears scoreboard: dependent issues at once after restart ----
      clr_mem;
      mem[0] = w_sub; mem[1] = w_inc;
      boot;
      tick;
      chk("t6b_sub", instr_out, w_sub);
      stop = 1; start = 1;
      tick;
      stop = 0; start = 0;
      chk("t6b_idle", 32'(state), 0);
      chk("t6b_pc", 32'(imem_addr), 1);
      start = 1;
      tick;
      start = 0;
      chk("t6b_run", 32'(state), 1);
      tick;
      chk("t6b_dep_v",  32'(instr_valid), 1);
      chk("t6b_dep_pc", 32'(pc_out), 1);
      chk("t6b_stall",  32'(stall_cnt), 0);

      // ---- async reset mid-stall ----
      clr_mem;
      mem[0] = w_sub; mem[1] = w_incm;
      boot;
      tick; tick;
      chk("t7_pre_stall", 32'(stall_cnt), 1);
      #2 reset_n = 0;
      #1;
      chk("t7_instr", instr_out, 32'h0);
      chk("t7_valid", 32'(instr_valid), 0);
      chk("t7_pcout", 32'(pc_out), 0);
      chk("t7_stall", 32'(stall_cnt), 0);
      chk("t7_state", 32'(state), 0);
      chk("t7_addr",  32'(imem_addr), 0);
      tick;
      reset_n = 1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
